// File: rtl/biquad_out_stage.sv
// Output stage for the biquad filter: saturating Q-shift conversion, a small
// sample FIFO, and a presenter FSM that holds each sample on the IO pads.
module biquad_out_stage #(
    parameter int DEPTH = 8,
    parameter int SHIFT = 14
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [31:0]              in_data,
    input  logic [15:0]              hold_cycles,
    input  logic                     clr_overflow,
    output logic [15:0]              io_out,
    output logic [15:0]              io_oeb,
    output logic                     out_strobe,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    hold_cnt_q, hold_cnt_d;
    logic [15:0]    hold_load;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [15:0]    mem [DEPTH];

    logic           push, pop, push_acc, drop;
    logic           fifo_full, fifo_empty;
    logic signed [31:0] shifted;
    logic [15:0]    sat_data;

    // Input has no back-pressure: in_valid is a one-cycle strobe with no ready.
    // A push that meets a full FIFO with no same-cycle pop is dropped and
    // recorded in the sticky overflow flag.
    assign push       = in_valid && enable;
    assign fifo_full  = (fifo_count == CW'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push_acc   = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;

    assign shifted = $signed(in_data) >>> SHIFT;

    always_comb begin
        sat_data = shifted[15:0];
        if (shifted > 32'sd32767)
            sat_data = 16'h7FFF;
        else if (shifted < -32'sd32768)
            sat_data = 16'h8000;
    end

    // A hold of zero behaves as one cycle.
    assign hold_load = (hold_cycles == 16'd0) ? 16'd0 : hold_cycles - 16'd1;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    hold_cnt_d = hold_load;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_q != 16'd0) begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    hold_cnt_d = hold_load;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && push_acc)
            mem[wr_ptr] <= sat_data;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            hold_cnt_q <= 16'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            io_out     <= 16'h0000;
            io_oeb     <= 16'hFFFF;
            out_strobe <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            io_oeb     <= {16{~enable}};
            out_strobe <= pop;
            if (push_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                io_out <= mem[rd_ptr];
            end
            case ({push_acc, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;
        end
    end

    assign fsm_state = logic'(state_q);

endmodule

// File: tb/tb_biquad_out_stage.sv
// Directed bench for biquad_out_stage: conversion, latency, hold timing,
// FIFO full/overflow behaviour and reset, with an expected-output queue.
module tb_biquad_out_stage;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        enable;
  logic        in_valid;
  logic [31:0] in_data;
  logic [15:0] hold_cycles;
  logic        clr_overflow;
  logic [15:0] io_out;
  logic [15:0] io_oeb;
  logic        out_strobe;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        fsm_state;

  biquad_out_stage #(.DEPTH(8), .SHIFT(14)) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .hold_cycles  (hold_cycles),
    .clr_overflow (clr_overflow),
    .io_out       (io_out),
    .io_oeb       (io_oeb),
    .out_strobe   (out_strobe),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int exp_gap = 0;
  bit mon_on = 1'b0;
  bit gap_on = 1'b0;
  bit have_last = 1'b0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 ns later; the scoreboard consumes strobes.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
    cyc++;
    if (mon_on && out_strobe) begin
      if (exp_q.size() == 0) begin
        check("stray_strobe", 32'(out_strobe), 32'd0);
      end else begin
        check("out_val", 32'(io_out), 32'(exp_q.pop_front()));
        if (gap_on && have_last)
          check("out_gap", cyc - last_cyc, exp_gap);
        last_cyc = cyc;
        have_last = 1'b1;
      end
    end
  endtask

  // driver tasks
  task automatic do_reset();
    enable = 1'b1;
    in_valid = 1'b0;
    clr_overflow = 1'b0;
    mon_on = 1'b0;
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    tick();
    exp_q.delete();
    have_last = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    in_valid = 1'b1;
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] smp(input int k);
    return 32'(k) << 14;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic sat_case(input string tag, input logic [31:0] d, input logic [15:0] exp);
    push(d);
    tick();
    check(tag, 32'(io_out), 32'(exp));
    check({tag, "_strobe"}, 32'(out_strobe), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, with in_valid asserted throughout
    wb_rst_i = 1'b1;
    enable = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h0000_4000;
    hold_cycles = 16'd4;
    clr_overflow = 1'b0;
    tick();
    tick();
    check("rst_io_out", 32'(io_out), 32'h0);
    check("rst_io_oeb", 32'(io_oeb), 32'hFFFF);
    check("rst_strobe", 32'(out_strobe), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_fsm", 32'(fsm_state), 32'd0);
    in_valid = 1'b0;
    wb_rst_i = 1'b0;
    tick();
    check("post_rst_oeb", 32'(io_oeb), 32'h0000);
    check("post_rst_count", 32'(fifo_count), 32'd0);
    check("post_rst_strobe", 32'(out_strobe), 32'd0);

    // latency: push after edge N, visible after edge N+2
    in_valid = 1'b1;
    in_data = 32'h0000_4000;
    tick();
    in_valid = 1'b0;
    check("lat_count1", 32'(fifo_count), 32'd1);
    check("lat_strobe_early", 32'(out_strobe), 32'd0);
    tick();
    check("lat_io_out", 32'(io_out), 32'h0001);
    check("lat_strobe", 32'(out_strobe), 32'd1);
    check("lat_count0", 32'(fifo_count), 32'd0);
    check("lat_fsm_hold", 32'(fsm_state), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lat_hold_fsm", 32'(fsm_state), 32'd1);
      check("lat_hold_out", 32'(io_out), 32'h0001);
      check("lat_hold_strobe", 32'(out_strobe), 32'd0);
    end
    tick();
    check("lat_idle", 32'(fsm_state), 32'd0);
    check("lat_keep_out", 32'(io_out), 32'h0001);

    // conversion and saturation
    hold_cycles = 16'd1;
    sat_case("sat_pos_max", 32'h7FFF_FFFF, 16'h7FFF);
    sat_case("sat_neg_max", 32'h8000_0000, 16'h8000);
    sat_case("minus_one",   32'hFFFF_C000, 16'hFFFF);
    sat_case("trunc_pos",   32'h0000_7FFF, 16'h0001);
    sat_case("floor_neg",   32'hFFFF_A000, 16'hFFFE);
    sat_case("lim_pos",     32'h1FFF_C000, 16'h7FFF);
    sat_case("over_pos",    32'h2000_0000, 16'h7FFF);
    sat_case("lim_neg",     32'hE000_0000, 16'h8000);
    sat_case("over_neg",    32'hDFFF_C000, 16'h8000);

    // back-to-back sequence, hold 3, no gaps
    do_reset();
    hold_cycles = 16'd3;
    for (int k = 1; k <= 10; k++) exp_q.push_back(16'(k));
    exp_q.push_back(16'h00FF);
    exp_q.push_back(16'h0000);
    gap_on = 1'b1;
    exp_gap = 3;
    mon_on = 1'b1;
    for (int k = 1; k <= 10; k++) push(smp(k));
    push(smp(255));
    push(32'h0);
    drain(100);
    check("seq_overflow", 32'(overflow), 32'd0);
    check("seq_count", 32'(fifo_count), 32'd0);
    repeat (5) tick();

    // hold_cycles of zero acts as one
    do_reset();
    hold_cycles = 16'd0;
    exp_q = '{16'h0011, 16'h0012, 16'h0013};
    exp_gap = 1;
    mon_on = 1'b1;
    push(smp(17));
    push(smp(18));
    push(smp(19));
    drain(20);

    // hold_cycles sampled only at load
    do_reset();
    hold_cycles = 16'd2;
    exp_q = '{16'h0021, 16'h0022, 16'h0023};
    exp_gap = 2;
    mon_on = 1'b1;
    push(smp(33));
    push(smp(34));
    hold_cycles = 16'd6;
    push(smp(35));
    tick();
    exp_gap = 6;
    drain(20);

    // overflow: 10 pushes, long hold
    do_reset();
    gap_on = 1'b0;
    hold_cycles = 16'd100;
    for (int k = 1; k <= 10; k++) push(smp(16'h30 + k));
    check("ovf_count", 32'(fifo_count), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    in_valid = 1'b1;
    in_data = smp(16'h77);
    clr_overflow = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    check("ovf_count_drop", 32'(fifo_count), 32'd8);
    tick();
    clr_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    hold_cycles = 16'd1;
    for (int k = 2; k <= 9; k++) exp_q.push_back(16'(16'h30 + k));
    mon_on = 1'b1;
    drain(200);
    repeat (5) tick();

    // full FIFO with coincident push and pop
    do_reset();
    hold_cycles = 16'd8;
    for (int k = 1; k <= 10; k++) exp_q.push_back(16'(16'h40 + k));
    gap_on = 1'b1;
    exp_gap = 8;
    mon_on = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      push(smp(16'h40 + k));
      if (k == 9) check("full_count_before", 32'(fifo_count), 32'd8);
      if (k == 10) begin
        check("full_count_same", 32'(fifo_count), 32'd8);
        check("full_no_ovf", 32'(overflow), 32'd0);
        check("full_pop_strobe", 32'(out_strobe), 32'd1);
      end
    end
    drain(120);
    check("full_ovf_end", 32'(overflow), 32'd0);

    // enable low: no pushes, queue still drains, pads released
    do_reset();
    gap_on = 1'b0;
    hold_cycles = 16'd2;
    exp_q = '{16'h0051, 16'h0052};
    mon_on = 1'b1;
    push(smp(16'h51));
    push(smp(16'h52));
    enable = 1'b0;
    push(smp(16'h5F));
    check("dis_count", 32'(fifo_count), 32'd1);
    check("dis_oeb", 32'(io_oeb), 32'hFFFF);
    drain(20);
    repeat (4) tick();
    enable = 1'b1;

    // reset mid-operation
    do_reset();
    hold_cycles = 16'd50;
    for (int k = 1; k <= 6; k++) push(smp(16'h60 + k));
    check("mid_count", 32'(fifo_count), 32'd5);
    check("mid_fsm", 32'(fsm_state), 32'd1);
    wb_rst_i = 1'b1;
    in_valid = 1'b1;
    in_data = smp(16'h6F);
    tick();
    check("mid_rst_out", 32'(io_out), 32'h0);
    check("mid_rst_oeb", 32'(io_oeb), 32'hFFFF);
    check("mid_rst_strobe", 32'(out_strobe), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_fsm", 32'(fsm_state), 32'd0);
    wb_rst_i = 1'b0;
    in_valid = 1'b0;
    tick();
    check("mid_rel_strobe", 32'(out_strobe), 32'd0);
    check("mid_rel_count", 32'(fifo_count), 32'd0);
    exp_q.delete();
    mon_on = 1'b1;
    repeat (20) tick();
    check("mid_no_stale", 32'(io_out), 32'h0);
    mon_on = 1'b0;

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
